exec_pipe_stage: RTL and testbench
==================================

# exec_pipe_stage

Parameterised, registered execute stage for the LEGv8 pipeline, placed between the ID/EX latch and the memory-access stage. It selects the second ALU operand, runs the ALU (logic, add/sub, pass, NOR, shifts, optional iterative multiply), and resolves B/CBZ/CBNZ branches. Results go into a single EX/MEM output register with a valid/ready handshake, so a multi-cycle op or a stalled memory stage back-pressures decode. Flush support allows squashing on a taken branch.

## Interface
- DATA_W, 64, datapath and address width
- REG_ADDR_W, 5, destination register index width
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ID/EX holds a valid instruction
- in_ready  out  1  stage accepts this cycle
- flush  in  1  squash output register and any in-flight multiply
- pc  in  DATA_W  instruction address
- op_a, op_b  in  DATA_W  register operands 1 and 2
- imm  in  DATA_W  sign-extended immediate
- alu_src  in  2  00 op_b, 01 imm, 10 zero-extended imm[11:0], 11 illegal
- alu_op  in  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass B, 1100 NOR, 0011 LSL, 0100 LSR, 1000 MUL
- br_uncond, br_zero, br_nonzero  in  1  B, CBZ, CBNZ
- mem_read, mem_write, mem_to_reg, reg_write  in  1  control, carried through
- rd  in  REG_ADDR_W  destination register
- out_valid  out  1  EX/MEM register valid
- out_ready  in  1  memory stage consumes
- ex_result, ex_store_data, branch_target  out  DATA_W  ALU result, op_b copy, pc + (imm << 2)
- ex_rd  out  REG_ADDR_W; ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  out  1
- ex_zero, pc_src, ex_illegal  out  1  result==0, branch taken, illegal alu_op/alu_src

## Operation
- B operand = mux(alu_src). Shift amount for LSL/LSR = B[$clog2(DATA_W)-1:0]; LSR is logical.
- All arithmetic is modulo 2^DATA_W; no carry or overflow outputs. MUL returns the low DATA_W bits of the product.
- branch_target = pc + (imm << 2), truncated. pc_src = br_uncond | (br_zero & zero) | (br_nonzero & !zero). pc_src is registered with the result and is only meaningful while out_valid is high.
- Illegal alu_op or alu_src=11: ex_result=0, ex_zero=1, ex_illegal=1, pc_src forced 0, reg_write/mem_write forced 0. Completes in one cycle.
- in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush.
- Accept = in_valid & in_ready. A non-MUL accept loads every ex_* output, and out_valid=1, on that edge.
- Output register clears when out_ready & out_valid and no new load occurs that edge.
- MUL FSM (shift-add, one multiplier bit per cycle):
  - IDLE → MUL on a MUL accept; latches the operands and sets cnt=0.
  - MUL: advances one bit per edge. On the final bit (cnt=DATA_W-1) it loads the output register and goes to IDLE if the output is free; otherwise it goes to DONE.
  - DONE → IDLE when the output frees; loads the output on that edge.
- flush has priority over everything. Next edge: out_valid=0, FSM to IDLE, accumulator discarded, no accept that cycle.

## Timing
- Reset: all outputs 0, out_valid=0, FSM IDLE, accumulator 0. in_ready reads 1 once rst_n is high.
- Non-MUL latency: accepted at edge N → out_valid high after edge N. Full throughput of 1 per cycle while out_ready=1.
- MUL latency: accepted at edge N → result loaded at edge N+DATA_W if out_ready allows. in_ready=0 from edge N until the FSM returns to IDLE.
- Outputs hold stable while out_valid & !out_ready.
- rst_n asserted mid-MUL aborts immediately and asynchronously to reset values.

## Configuration
- EXEC_MUL_EN defined: MUL op, FSM, and accumulator are compiled in, as described above.
- EXEC_MUL_EN undefined: no FSM; state is permanently IDLE. alu_op 1000 is treated as illegal: single cycle, ex_result=0, ex_illegal=1.

## Test plan
- ADD: op_a=5, op_b=7, alu_src=00, alu_op=0010, out_ready=1 → next cycle ex_result=12, ex_zero=0, out_valid=1, ex_illegal=0.
- CBZ: alu_op=0111, op_b=0, br_zero=1, pc=0x100, imm=4 → ex_zero=1, pc_src=1, branch_target=0x110. Same stimulus with op_b=9 → pc_src=0.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 and in_valid=1 → in_ready=0 and outputs unchanged. out_ready=1 → the waiting instruction is accepted on that edge.
- MUL (EXEC_MUL_EN, DATA_W=64): op_a=3, op_b=0xFFFFFFFFFFFFFFFF → out_valid 64 cycles after accept, ex_result=0xFFFFFFFFFFFFFFFD, in_ready=0 throughout. Without the macro → ex_illegal=1, ex_result=0, one cycle.
- Flush 10 cycles into a MUL → out_valid never rises for that op; in_ready=1 the cycle after the flush; the next ADD completes normally.
- Illegal alu_op=1111 with reg_write=1 → ex_illegal=1, ex_reg_write=0, ex_result=0. rst_n pulsed low mid-MUL → all outputs 0 immediately, FSM IDLE.

Source files
------------

// File: rtl/exec_pipe_stage.sv
// LEGv8 execute stage: operand select, ALU, branch resolve and EX/MEM output register.
// Optional macro EXEC_MUL_EN compiles in the iterative shift-add multiplier (alu_op 1000).
module exec_pipe_stage #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     pc,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    input  logic [DATA_W-1:0]     imm,
    input  logic [1:0]            alu_src,
    input  logic [3:0]            alu_op,
    input  logic                  br_uncond,
    input  logic                  br_zero,
    input  logic                  br_nonzero,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_to_reg,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     ex_result,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic [DATA_W-1:0]     branch_target,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_reg_write,
    output logic                  ex_zero,
    output logic                  pc_src,
    output logic                  ex_illegal
);

    localparam int SH_W = $clog2(DATA_W);

    typedef struct packed {
        logic [DATA_W-1:0]     store_data;
        logic [DATA_W-1:0]     target;
        logic [REG_ADDR_W-1:0] rd;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic                  br_uncond;
        logic                  br_zero;
        logic                  br_nonzero;
    } ctl_t;

    logic [DATA_W-1:0] b_p0;
    logic [DATA_W-1:0] alu_res_p0;
    logic              src_ill;
    logic              op_ill;
    logic              illegal_p0;
    ctl_t              ctl_p0;
    logic              accept;
    logic              out_free;
    logic              idle;
    logic              load;
    ctl_t              ld_ctl;
    logic [DATA_W-1:0] ld_result;
    logic              ld_illegal;
    logic              ld_zero;
    logic              ld_pc_src;

`ifdef EXEC_MUL_EN
    localparam int               CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] mcand_p1;
    logic [DATA_W-1:0] mplier_p1;
    logic [DATA_W-1:0] acc_p1;
    logic [DATA_W-1:0] mul_sum;
    logic [DATA_W-1:0] mul_res;
    logic [CNT_W-1:0]  cnt_p1;
    ctl_t              hold_p1;
    logic              mul_op;
    logic              mul_start;
    logic              mul_load;
`endif

    // ---- stage p0: operand select, ALU, control squash for illegal ops
    always_comb begin
        src_ill = 1'b0;
        case (alu_src)
            2'b00:   b_p0 = op_b;
            2'b01:   b_p0 = imm;
            2'b10:   b_p0 = {{(DATA_W-12){1'b0}}, imm[11:0]};
            default: begin
                b_p0    = '0;
                src_ill = 1'b1;
            end
        endcase
    end

    always_comb begin
        alu_res_p0 = '0;
        op_ill     = 1'b0;
`ifdef EXEC_MUL_EN
        mul_op     = 1'b0;
`endif
        case (alu_op)
            4'b0000: alu_res_p0 = op_a & b_p0;
            4'b0001: alu_res_p0 = op_a | b_p0;
            4'b0010: alu_res_p0 = op_a + b_p0;
            4'b0110: alu_res_p0 = op_a - b_p0;
            4'b0111: alu_res_p0 = b_p0;
            4'b1100: alu_res_p0 = ~(op_a | b_p0);
            4'b0011: alu_res_p0 = op_a << b_p0[SH_W-1:0];
            4'b0100: alu_res_p0 = op_a >> b_p0[SH_W-1:0];
`ifdef EXEC_MUL_EN
            4'b1000: mul_op = 1'b1;
`endif
            default: op_ill = 1'b1;
        endcase
    end

    assign illegal_p0 = op_ill | src_ill;

    always_comb begin
        ctl_p0.store_data = op_b;
        ctl_p0.target     = pc + (imm << 2);
        ctl_p0.rd         = rd;
        ctl_p0.mem_read   = mem_read;
        ctl_p0.mem_write  = mem_write & ~illegal_p0;
        ctl_p0.mem_to_reg = mem_to_reg;
        ctl_p0.reg_write  = reg_write & ~illegal_p0;
        ctl_p0.br_uncond  = br_uncond;
        ctl_p0.br_zero    = br_zero;
        ctl_p0.br_nonzero = br_nonzero;
    end

    assign out_free = ~out_valid | out_ready;
    assign in_ready = idle & out_free & ~flush;
    assign accept   = in_valid & in_ready;

`ifdef EXEC_MUL_EN
    // ---- stage p1: shift-add multiplier, one multiplier bit per edge
    assign idle      = (state == IDLE);
    assign mul_start = accept & mul_op & ~src_ill;
    assign mul_sum   = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);
    assign mul_res   = (state == DONE) ? acc_p1 : mul_sum;
    assign mul_load  = ~flush & out_free &
                       (((state == MUL) & (cnt_p1 == LAST)) | (state == DONE));
    assign load      = (accept & ~mul_start) | mul_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (mul_start) state_nx = MUL;
                MUL:     if (cnt_p1 == LAST) state_nx = out_free ? IDLE : DONE;
                DONE:    if (out_free) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_p1  <= '0;
            mplier_p1 <= '0;
            acc_p1    <= '0;
            cnt_p1    <= '0;
            hold_p1   <= '0;
        end else if (flush) begin
            acc_p1 <= '0;
            cnt_p1 <= '0;
        end else if (mul_start) begin
            mcand_p1  <= op_a;
            mplier_p1 <= b_p0;
            acc_p1    <= '0;
            cnt_p1    <= '0;
            hold_p1   <= ctl_p0;
        end else if (state == MUL) begin
            acc_p1    <= mul_sum;
            mcand_p1  <= mcand_p1 << 1;
            mplier_p1 <= mplier_p1 >> 1;
            cnt_p1    <= cnt_p1 + CNT_W'(1);
        end
    end
`else
    assign idle = 1'b1;
    assign load = accept;
`endif

    // ---- EX/MEM output register: single-cycle ops load from p0, MUL from the p1 holding regs
    always_comb begin
        ld_ctl     = ctl_p0;
        ld_result  = illegal_p0 ? '0 : alu_res_p0;
        ld_illegal = illegal_p0;
`ifdef EXEC_MUL_EN
        if (state != IDLE) begin
            ld_ctl     = hold_p1;
            ld_result  = mul_res;
            ld_illegal = 1'b0;
        end
`endif
        ld_zero   = (ld_result == '0);
        ld_pc_src = ~ld_illegal & (ld_ctl.br_uncond | (ld_ctl.br_zero & ld_zero) |
                                   (ld_ctl.br_nonzero & ~ld_zero));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            ex_result     <= '0;
            ex_store_data <= '0;
            branch_target <= '0;
            ex_rd         <= '0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_zero       <= 1'b0;
            pc_src        <= 1'b0;
            ex_illegal    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid     <= 1'b1;
            ex_result     <= ld_result;
            ex_store_data <= ld_ctl.store_data;
            branch_target <= ld_ctl.target;
            ex_rd         <= ld_ctl.rd;
            ex_mem_read   <= ld_ctl.mem_read;
            ex_mem_write  <= ld_ctl.mem_write;
            ex_mem_to_reg <= ld_ctl.mem_to_reg;
            ex_reg_write  <= ld_ctl.reg_write;
            ex_zero       <= ld_zero;
            pc_src        <= ld_pc_src;
            ex_illegal    <= ld_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exec_pipe_stage.sv
// Directed scoreboard bench for exec_pipe_stage (DATA_W=64); MUL steps depend on EXEC_MUL_EN.
module tb_exec_pipe_stage;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
        logic [1:0]  src;
        logic [3:0]  aop;
        logic        bu, bz, bnz, mr, mw, mtr, rw;
        logic [4:0]  rd;
    } stim_t;

    typedef struct packed {
        logic [63:0] result;
        logic [63:0] target;
        logic [63:0] store;
        logic [4:0]  rd;
        logic        zero, pc_src, illegal, mr, mw, mtr, rw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    stim_t       s = '0;
    logic        in_ready, out_valid;
    logic [63:0] ex_result, ex_store_data, branch_target;
    logic [4:0]  ex_rd;
    logic        ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
    logic        ex_zero, pc_src, ex_illegal;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   lat;
    logic seen;

    always #5 clk = ~clk;

    exec_pipe_stage #(.DATA_W(64), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .pc(s.pc), .op_a(s.a), .op_b(s.b), .imm(s.imm), .alu_src(s.src), .alu_op(s.aop),
        .br_uncond(s.bu), .br_zero(s.bz), .br_nonzero(s.bnz),
        .mem_read(s.mr), .mem_write(s.mw), .mem_to_reg(s.mtr), .reg_write(s.rw), .rd(s.rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .branch_target(branch_target),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_zero(ex_zero), .pc_src(pc_src), .ex_illegal(ex_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic stim_t mk(input logic [3:0] aop, input logic [1:0] src, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] imm, input logic [63:0] pc);
        stim_t t;
        t = '0;
        t.aop = aop; t.src = src; t.a = a; t.b = b; t.imm = imm; t.pc = pc;
        t.rd = {1'b1, aop};
        return t;
    endfunction

    function automatic exp_t model(input stim_t t);
        exp_t        e;
        logic [63:0] b, r;
        logic        ill;
        ill = 1'b0;
        r   = '0;
        case (t.src)
            2'd0:    b = t.b;
            2'd1:    b = t.imm;
            2'd2:    b = {52'd0, t.imm[11:0]};
            default: begin b = '0; ill = 1'b1; end
        endcase
        case (t.aop)
            4'b0000: r = t.a & b;
            4'b0001: r = t.a | b;
            4'b0010: r = t.a + b;
            4'b0110: r = t.a - b;
            4'b0111: r = b;
            4'b1100: r = ~(t.a | b);
            4'b0011: r = t.a << b[5:0];
            4'b0100: r = t.a >> b[5:0];
`ifdef EXEC_MUL_EN
            4'b1000: r = t.a * b;
`endif
            default: ill = 1'b1;
        endcase
        if (ill) r = '0;
        e.result  = r;
        e.zero    = (r == 64'd0);
        e.pc_src  = !ill && (t.bu || (t.bz && e.zero) || (t.bnz && !e.zero));
        e.illegal = ill;
        e.target  = t.pc + (t.imm << 2);
        e.store   = t.b;
        e.rd      = t.rd;
        e.mr      = t.mr;
        e.mtr     = t.mtr;
        e.mw      = t.mw && !ill;
        e.rw      = t.rw && !ill;
        return e;
    endfunction

    task automatic cmp_out(input exp_t e);
        chk("result", ex_result, e.result);
        chk("target", branch_target, e.target);
        chk("store_data", ex_store_data, e.store);
        chk("rd", 64'(ex_rd), 64'(e.rd));
        chk1("zero", ex_zero, e.zero);
        chk1("pc_src", pc_src, e.pc_src);
        chk1("illegal", ex_illegal, e.illegal);
        chk1("mem_read", ex_mem_read, e.mr);
        chk1("mem_write", ex_mem_write, e.mw);
        chk1("mem_to_reg", ex_mem_to_reg, e.mtr);
        chk1("reg_write", ex_reg_write, e.rw);
    endtask

    // Called at posedge+1: evaluates handshakes just before the next edge, then advances.
    task automatic cycle();
        exp_t e;
        #2;
        if (flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                assert (q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_unexpected_output observed=out_valid expected=no_pending");
                end
                if (q.size() != 0) begin
                    e = q.pop_front();
                    cmp_out(e);
                end
            end
            if (in_valid && in_ready) q.push_back(model(s));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", ex_result, 64'd0);
        chk1("rst_pc_src", pc_src, 1'b0);
        chk1("rst_illegal", ex_illegal, 1'b0);
        rst_n = 1'b1;
        #1;
        chk1("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // ADD 5+7, single-cycle latency
        s = mk(4'b0010, 2'd0, 64'd5, 64'd7, 64'd0, 64'd0);
        s.rw = 1'b1;
        in_valid = 1'b1;
        cycle();
        chk1("add_valid", out_valid, 1'b1);
        chk("add_result", ex_result, 64'd12);
        chk1("add_zero", ex_zero, 1'b0);
        chk1("add_illegal", ex_illegal, 1'b0);

        // CBZ taken / not taken, back to back
        s = mk(4'b0111, 2'd0, 64'd0, 64'd0, 64'd4, 64'h100);
        s.bz = 1'b1;
        cycle();
        chk1("cbz_zero", ex_zero, 1'b1);
        chk1("cbz_pc_src", pc_src, 1'b1);
        chk("cbz_target", branch_target, 64'h110);
        s.b = 64'd9;
        cycle();
        chk1("cbz_nt_pc_src", pc_src, 1'b0);

        // remaining ALU functions and operand sources
        s = mk(4'b0000, 2'd0, 64'hF0F0, 64'hFF00, 64'd0, 64'd0); s.mr = 1'b1; s.mtr = 1'b1;
        cycle();
        s = mk(4'b0001, 2'd0, 64'hF0F0, 64'h0F0F, 64'd0, 64'd0); s.mw = 1'b1;
        cycle();
        s = mk(4'b0110, 2'd0, 64'd3, 64'd5, 64'd0, 64'd0);
        cycle();
        chk("sub_wrap", ex_result, 64'hFFFF_FFFF_FFFF_FFFE);
        s = mk(4'b0011, 2'd1, 64'd1, 64'd0, 64'd63, 64'd0);
        cycle();
        chk("lsl_63", ex_result, 64'h8000_0000_0000_0000);
        s = mk(4'b0100, 2'd0, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'd0);
        cycle();
        chk("lsr_logical", ex_result, 64'h0800_0000_0000_0000);
        s = mk(4'b1100, 2'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        cycle();
        s = mk(4'b0111, 2'd2, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        cycle();
        chk("src_zext12", ex_result, 64'hFFF);
        s = mk(4'b0111, 2'd0, 64'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 64'h200); s.bnz = 1'b1;
        cycle();
        chk1("cbnz_pc_src", pc_src, 1'b1);
        chk("cbnz_target", branch_target, 64'h1F8);
        s = mk(4'b0010, 2'd0, 64'd1, 64'd1, 64'd8, 64'd0); s.bu = 1'b1;
        cycle();

        // illegal alu_op and alu_src
        s = mk(4'b1111, 2'd0, 64'd5, 64'd7, 64'd0, 64'd0); s.rw = 1'b1; s.mw = 1'b1;
        cycle();
        chk1("ill_op_flag", ex_illegal, 1'b1);
        chk1("ill_op_reg_write", ex_reg_write, 1'b0);
        chk("ill_op_result", ex_result, 64'd0);
        s = mk(4'b0010, 2'd3, 64'd5, 64'd7, 64'd0, 64'd0); s.bu = 1'b1; s.rw = 1'b1;
        cycle();
        chk1("ill_src_pc_src", pc_src, 1'b0);
`ifndef EXEC_MUL_EN
        s = mk(4'b1000, 2'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0);
        cycle();
        chk1("nomul_valid", out_valid, 1'b1);
        chk1("nomul_illegal", ex_illegal, 1'b1);
        chk("nomul_result", ex_result, 64'd0);
`endif
        in_valid = 1'b0;
        cycle();

        // back-pressure: output held, next instruction waits
        out_ready = 1'b0;
        s = mk(4'b0010, 2'd0, 64'd1, 64'd2, 64'd0, 64'd0);
        in_valid = 1'b1;
        cycle();
        s = mk(4'b0010, 2'd0, 64'd10, 64'd20, 64'd0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_valid", out_valid, 1'b1);
            chk("bp_hold", ex_result, 64'd3);
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_release", ex_result, 64'd30);
        in_valid = 1'b0;
        cycle();

        // flush squashes a held result
        out_ready = 1'b0;
        s = mk(4'b0010, 2'd0, 64'd4, 64'd4, 64'd0, 64'd0);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk1("flush_in_ready", in_ready, 1'b0);
        cycle();
        flush = 1'b0;
        out_ready = 1'b1;
        #1;
        chk1("flush_valid", out_valid, 1'b0);
        chk1("flush_ready_after", in_ready, 1'b1);

`ifdef EXEC_MUL_EN
        // MUL latency and result
        s = mk(4'b1000, 2'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            chk1("mul_in_ready", in_ready, 1'b0);
            cycle();
            lat++;
        end
        chk("mul_latency", 64'(lat), 64'd64);
        chk("mul_result", ex_result, 64'hFFFF_FFFF_FFFF_FFFD);
        cycle();

        // flush 10 cycles into a MUL
        s = mk(4'b1000, 2'd0, 64'd6, 64'd7, 64'd0, 64'd0);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (9) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk1("mflush_ready", in_ready, 1'b1);
        seen = 1'b0;
        repeat (70) begin
            seen = seen | out_valid;
            cycle();
        end
        chk1("mflush_no_valid", seen, 1'b0);

        // reset mid-MUL
        s = mk(4'b1000, 2'd0, 64'd6, 64'd7, 64'd0, 64'd0);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (5) cycle();
`else
        out_ready = 1'b0;
        s = mk(4'b0010, 2'd0, 64'd6, 64'd7, 64'd0, 64'd0);
        s.rw = 1'b1;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk1("pre_rst_valid", out_valid, 1'b1);
`endif
        rst_n = 1'b0;
        #1;
        chk1("arst_valid", out_valid, 1'b0);
        chk("arst_result", ex_result, 64'd0);
        chk1("arst_reg_write", ex_reg_write, 1'b0);
        chk("arst_rd", 64'(ex_rd), 64'd0);
        q.delete();
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk1("arst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // normal ADD after flush/reset
        s = mk(4'b0010, 2'd0, 64'd100, 64'd23, 64'd0, 64'd0);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("post_add", ex_result, 64'd123);
        cycle();
        cycle();
        chk("sb_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
